stream_mux_rr: RTL and testbench

- Parametrised successor to the team's 4:1 two-bit combinational multiplexer.
- Selects one of NUM_CH input streams, each WIDTH bits wide, and drives a single registered output stream using valid/ready handshakes.
- Two selection modes: manual (SEL port) and round-robin arbitration.
- Sits between multiple producers and one shared downstream consumer.

---
 rtl/stream_mux_pkg.sv | 18 +
 rtl/stream_mux_rr_arbiter.sv | 40 ++++
 rtl/stream_mux_rr.sv | 131 +++++++++++++
 tb/tb_stream_mux_rr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the stream_mux_rr block and its round-robin arbiter.
//   MODE_MANUAL / MODE_RR : encodings of the MODE input.
//   clog2_min1()          : channel-index width. It never returns 0, so a
//                           single-channel instance still has a legal
//                           one-bit index.
// ---------------------------------------------------------------------------
package stream_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. The search starts at
// channel ptr+1 and wraps modulo NUM_CH. It grants the first requester
// found. The pointer register itself lives in the parent.
//
// Ports:
//   req   [NUM_CH] : per-channel request (valid) bits
//   ptr   [SEL_W]  : last granted channel; it has lowest priority
//   gnt   [SEL_W]  : granted channel index (0 when nothing requests)
//   gnt_v          : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]                 req,
   input  logic [clog2_min1(NUM_CH)-1:0]     ptr,
   output logic [clog2_min1(NUM_CH)-1:0]     gnt,
   output logic                              gnt_v
);

   localparam int SEL_W = clog2_min1(NUM_CH);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      gnt = '0;
      // Walk from the farthest candidate to the nearest. The last hit
      // overwrites earlier ones, so the channel closest to ptr+1 wins
      // without needing a loop break.
      for (int k = NUM_CH; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % NUM_CH])
            gnt = SEL_W'((int'(ptr) + k) % NUM_CH);
      end
      gnt_v = |req;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// Selects one of NUM_CH valid/ready input streams into a single registered
// output stage. There is no skid buffer: a new word is accepted only when
// the output register is empty or is being drained in the same cycle.
// Selection is either manual (SEL) or round-robin between the valid channels.
//
// Optional feature: define STREAM_MUX_TX_COUNT_EN to add TX_COUNT. TX_COUNT
// is a 16-bit wrapping count of completed output transfers.
//
// Ports:
//   CLK, RST          : clock; asynchronous active-high reset
//   IN_DATA  [NUM_CH*WIDTH] : channel i in bits [i*WIDTH +: WIDTH]
//   IN_VALID [NUM_CH]  : per-channel valid
//   IN_READY [NUM_CH]  : per-channel ready (combinational, one-hot or zero)
//   MODE               : MODE_MANUAL (0) or MODE_RR (1)
//   SEL      [SEL_W]   : channel index used in manual mode
//   OUT_DATA/OUT_VALID : registered output word and valid
//   OUT_READY          : downstream ready
//   OUT_CH   [SEL_W]   : channel that sourced OUT_DATA
//   TX_COUNT [16]      : completed transfers (only with STREAM_MUX_TX_COUNT_EN)
// ---------------------------------------------------------------------------
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = clog2_min1(NUM_CH)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_CH*WIDTH-1:0]   IN_DATA,
   input  logic [NUM_CH-1:0]         IN_VALID,
   output logic [NUM_CH-1:0]         IN_READY,
   input  logic                      MODE,
   input  logic [SEL_W-1:0]          SEL,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [SEL_W-1:0]          OUT_CH
`ifdef STREAM_MUX_TX_COUNT_EN
   ,
   output logic [15:0]               TX_COUNT
`endif
);

   logic             can_load;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_gnt;
   logic             rr_gnt_v;
   logic             man_v;
   logic [SEL_W-1:0] gnt;
   logic             gnt_v;
   logic [WIDTH-1:0] gnt_data;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req   (IN_VALID),
      .ptr   (ptr),
      .gnt   (rr_gnt),
      .gnt_v (rr_gnt_v)
   );

   always_comb begin
      can_load = !OUT_VALID || OUT_READY;

      // Decoding SEL with an equality loop makes an out-of-range index
      // (SEL >= NUM_CH) read as "not valid" rather than indexing past the
      // vector.
      man_v = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (SEL == SEL_W'(i))
            man_v = IN_VALID[i];
      end

      if (MODE == MODE_RR) begin
         gnt   = rr_gnt;
         gnt_v = rr_gnt_v;
      end else begin
         gnt   = SEL;
         gnt_v = man_v;
      end

      gnt_data = '0;
      IN_READY = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt == SEL_W'(i)) begin
            gnt_data    = IN_DATA[i*WIDTH +: WIDTH];
            IN_READY[i] = can_load && gnt_v;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments. All flops then
   // sample pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_CH    <= '0;
         // Pointing at the last channel gives channel 0 first priority.
         ptr       <= SEL_W'(NUM_CH - 1);
      end else if (can_load) begin
         if (gnt_v) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= gnt_data;
            OUT_CH    <= gnt;
            // Manual grants leave the fairness pointer alone.
            if (MODE == MODE_RR)
               ptr <= gnt;
         end else begin
            OUT_VALID <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_TX_COUNT_EN
   logic [15:0] tx_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         tx_cnt <= '0;
      else if (OUT_VALID && OUT_READY)
         tx_cnt <= tx_cnt + 16'd1;
   end

   assign TX_COUNT = tx_cnt;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed bench for stream_mux_rr with WIDTH=2 and NUM_CH=4. Channel data
// A..D = 00,01,10,11. Expected values are written out by hand for each
// vector. Inputs are driven 1 time unit after the rising edge, and outputs
// are sampled at that same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_mux_rr;

   localparam int WIDTH  = 2;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   localparam logic [NUM_CH*WIDTH-1:0] DATA_STD = 8'b11_10_01_00; // ch3..ch0
   localparam logic [NUM_CH*WIDTH-1:0] DATA_ALT = 8'b00_01_10_11;

   logic                    clk;
   logic                    rst;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_ch;
`ifdef STREAM_MUX_TX_COUNT_EN
   logic [15:0]             tx_count;
`endif

   int total = 0;
   int bad   = 0;

   stream_mux_rr #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .MODE      (mode),
      .SEL       (sel),
      .OUT_DATA  (out_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_CH    (out_ch)
`ifdef STREAM_MUX_TX_COUNT_EN
      ,
      .TX_COUNT  (tx_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge; return 1 unit later so outputs have settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] d,
                            input logic [1:0] ch);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".data"},  32'(out_data),  32'(d));
      check({tag, ".ch"},    32'(out_ch),    32'(ch));
   endtask

   initial begin
      logic [1:0] rr_exp [8];
      logic [1:0] skip_exp [4];
      logic [3:0] skip_rdy [4];

      rr_exp   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      skip_exp = '{2'd1, 2'd3, 2'd1, 2'd3};
      skip_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

      rst       = 1'b1;
      in_data   = DATA_STD;
      in_valid  = 4'b0000;
      mode      = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      #12;
      check_out("reset", 1'b0, 2'b00, 2'd0);
      check("reset.in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Manual sweep: SEL 0..3 picks A..D; IN_READY is one-hot on SEL.
      in_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         check($sformatf("man%0d.in_ready", s), 32'(in_ready), 32'(1 << s));
         step();
         check_out($sformatf("man%0d", s), 1'b1, 2'(s), 2'(s));
      end

      // Round-robin fairness. Manual grants left ptr at 3, so the sequence
      // starts at channel 0.
      mode = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check_out($sformatf("rr%0d", k), 1'b1, rr_exp[k], rr_exp[k]);
      end

      // Round-robin skip over idle channels 0 and 2 (ptr is 3 here).
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("skip%0d.in_ready", k), 32'(in_ready), 32'(skip_rdy[k]));
         step();
         check_out($sformatf("skip%0d", k), 1'b1, skip_exp[k], skip_exp[k]);
      end

      // Backpressure: load ch2, then stall while SEL and data change.
      mode     = 1'b0;
      in_valid = 4'b1111;
      sel      = 2'd2;
      step();
      check_out("bp.load", 1'b1, 2'b10, 2'd2);
      out_ready = 1'b0;
      in_data   = DATA_ALT;
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
         step();
         check_out($sformatf("bp%0d", k), 1'b1, 2'b10, 2'd2);
      end
      // One ready cycle drains the held word and loads ch1 of ALT (10).
      sel       = 2'd1;
      out_ready = 1'b1;
      #1;
      check("bp.release.in_ready", 32'(in_ready), 32'b0010);
      step();
      check_out("bp.release", 1'b1, 2'b10, 2'd1);

      // No valid input: OUT_VALID drops, data and channel hold.
      in_valid = 4'b0000;
      in_data  = DATA_STD;
      step();
      check_out("idle", 1'b0, 2'b10, 2'd1);

      // Mid-run reset in round-robin mode. Two grants move ptr to 1.
      mode     = 1'b1;
      in_valid = 4'b1111;
      step();
      check_out("pre_rst0", 1'b1, 2'b00, 2'd0);
      step();
      check_out("pre_rst1", 1'b1, 2'b01, 2'd1);
      #2 rst = 1'b1;
      #1;
      check_out("async_rst", 1'b0, 2'b00, 2'd0);
      #1 rst = 1'b0;
      step();
      check_out("post_rst", 1'b1, 2'b00, 2'd0);

      // Single requester: granted every cycle at full throughput.
      in_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step();
         check_out($sformatf("single%0d", k), 1'b1, 2'b10, 2'd2);
      end

`ifdef STREAM_MUX_TX_COUNT_EN
      rst = 1'b1;
      #1;
      check("tx.reset", 32'(tx_count), 32'h0);
      rst      = 1'b0;
      in_valid = 4'b1111;
      // First edge only loads; the next five each complete a transfer.
      for (int k = 0; k < 6; k++) step();
      check("tx.five", 32'(tx_count), 32'd5);
      force dut.tx_cnt = 16'hFFFF;
      #1;
      release dut.tx_cnt;
      step();
      check("tx.wrap", 32'(tx_count), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
